// File: rtl/rsa_avm_pkg.sv
// Shared definitions for the RSA UART feeder: controller states, default
// UART register map and status bit positions.
package rsa_avm_pkg;

    typedef enum logic [2:0] {
        S_POLL_RX   = 3'd0,
        S_READ_RX   = 3'd1,
        S_START     = 3'd2,
        S_WAIT_CORE = 3'd3,
        S_POLL_TX   = 3'd4,
        S_WRITE_TX  = 3'd5
    } state_t;

    localparam logic [4:0] DEF_RX_ADDR     = 5'd0;
    localparam logic [4:0] DEF_TX_ADDR     = 5'd4;
    localparam logic [4:0] DEF_STATUS_ADDR = 5'd8;

    localparam int DEF_TX_OK_BIT = 6;
    localparam int DEF_RX_OK_BIT = 7;

endpackage

// File: rtl/avm_single_access.sv
// One Avalon-MM access at a time: holds read/write with stable address and
// data until waitrequest drops, then pulses done with the captured readdata.
module avm_single_access
    import rsa_avm_pkg::*;
#(
    parameter logic [4:0] RESET_ADDR = DEF_STATUS_ADDR
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic        req,
    input  logic        req_write,
    input  logic [4:0]  req_address,
    input  logic [31:0] req_writedata,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        done,
    output logic [31:0] rdata
);

    logic        read_r;
    logic        write_r;
    logic [4:0]  address_r;
    logic [31:0] writedata_r;
    logic        done_r;
    logic [31:0] rdata_r;

    // Out of reset a status read is already on the bus; requests are only
    // accepted while the bus is idle.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            read_r      <= 1'b1;
            write_r     <= 1'b0;
            address_r   <= RESET_ADDR;
            writedata_r <= 32'd0;
            done_r      <= 1'b0;
            rdata_r     <= 32'd0;
        end else if ((read_r || write_r) && !avm_waitrequest) begin
            read_r  <= 1'b0;
            write_r <= 1'b0;
            done_r  <= 1'b1;
            rdata_r <= avm_readdata;
        end else if (req && !read_r && !write_r) begin
            read_r      <= !req_write;
            write_r     <= req_write;
            address_r   <= req_address;
            writedata_r <= req_writedata;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
        end
    end

    assign avm_read      = read_r;
    assign avm_write     = write_r;
    assign avm_address   = address_r;
    assign avm_writedata = writedata_r;
    assign done          = done_r;
    assign rdata         = rdata_r;

endmodule

// File: rtl/rsa_avm_uart_ctrl.sv
// Avalon-MM master that pulls key and ciphertext bytes from a UART, runs an
// external modexp core per block and returns the plaintext bytes over TX.
module rsa_avm_uart_ctrl
    import rsa_avm_pkg::*;
#(
    parameter int         KEY_BITS    = 256,
    parameter logic [4:0] RX_ADDR     = DEF_RX_ADDR,
    parameter logic [4:0] TX_ADDR     = DEF_TX_ADDR,
    parameter logic [4:0] STATUS_ADDR = DEF_STATUS_ADDR,
    parameter int         TX_OK_BIT   = DEF_TX_OK_BIT,
    parameter int         RX_OK_BIT   = DEF_RX_OK_BIT
) (
    input  logic                avm_clk,
    input  logic                avm_rst,
    output logic [4:0]          avm_address,
    output logic                avm_read,
    input  logic [31:0]         avm_readdata,
    output logic                avm_write,
    output logic [31:0]         avm_writedata,
    input  logic                avm_waitrequest,
    input  logic                key_reload,
    output logic                core_start,
    output logic [KEY_BITS-1:0] core_a,
    output logic [KEY_BITS-1:0] core_e,
    output logic [KEY_BITS-1:0] core_n,
    input  logic [KEY_BITS-1:0] core_result,
    input  logic                core_done,
    output logic                busy,
    output logic [15:0]         block_count
);

    localparam int KB        = KEY_BITS / 8;
    localparam int OUT_BYTES = KB - 1;
    localparam int CW        = $clog2(3 * KB + 1);

    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_KB     = CW'(KB);
    localparam logic [CW-1:0] CNT_2KB    = CW'(2 * KB);
    localparam logic [CW-1:0] CNT_LASTK  = CW'(3 * KB - 1);
    localparam logic [CW-1:0] CNT_LASTB  = CW'(KB - 1);
    localparam logic [CW-1:0] CNT_OUT    = CW'(OUT_BYTES);

    state_t              state_r, state_nxt_s;
    logic [CW-1:0]       cnt_r;
    logic [KEY_BITS-1:0] n_r, e_r, a_r, result_r;
    logic                need_key_r, reload_pend_r;
    logic                core_start_r, busy_r;
    logic [15:0]         block_count_r;

    logic        acc_req_s, acc_write_s, acc_done_s;
    logic [4:0]  acc_address_s;
    logic [31:0] acc_writedata_s, acc_rdata_s;
    logic        last_rx_s, last_tx_s, block_end_s, apply_reload_s;
    logic        unused_rdata_s;

    function automatic logic [KEY_BITS-1:0] shift_in(input logic [KEY_BITS-1:0] r,
                                                     input logic [7:0] b);
        return (r << 8) | {{(KEY_BITS-8){1'b0}}, b};
    endfunction

    avm_single_access #(
        .RESET_ADDR (STATUS_ADDR)
    ) u_access (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .req             (acc_req_s),
        .req_write       (acc_write_s),
        .req_address     (acc_address_s),
        .req_writedata   (acc_writedata_s),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .done            (acc_done_s),
        .rdata           (acc_rdata_s)
    );

    assign unused_rdata_s = ^acc_rdata_s;
    assign last_rx_s      = need_key_r ? (cnt_r == CNT_LASTK) : (cnt_r == CNT_LASTB);
    assign last_tx_s      = ((cnt_r + CNT_ONE) == CNT_OUT);
    assign block_end_s    = (state_r == S_WRITE_TX) && acc_done_s && last_tx_s;
    // A reload lands only between blocks, never while a load is partway in.
    assign apply_reload_s = (reload_pend_r || key_reload) &&
                            (block_end_s || ((state_r == S_POLL_RX) && (cnt_r == CNT_ZERO)));

    // State register.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_r <= S_POLL_RX;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and the bus request issued on each transition.
    always_comb begin
        state_nxt_s     = state_r;
        acc_req_s       = 1'b0;
        acc_write_s     = 1'b0;
        acc_address_s   = STATUS_ADDR;
        acc_writedata_s = {24'd0, result_r[KEY_BITS-9 -: 8]};
        case (state_r)
            S_POLL_RX: begin
                if (acc_done_s) begin
                    acc_req_s = 1'b1;
                    if (acc_rdata_s[RX_OK_BIT]) begin
                        state_nxt_s   = S_READ_RX;
                        acc_address_s = RX_ADDR;
                    end else begin
                        state_nxt_s = S_POLL_RX;
                    end
                end else begin
                    state_nxt_s = S_POLL_RX;
                end
            end
            S_READ_RX: begin
                if (acc_done_s) begin
                    if (last_rx_s) begin
                        state_nxt_s = S_START;
                    end else begin
                        state_nxt_s = S_POLL_RX;
                        acc_req_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = S_READ_RX;
                end
            end
            S_START: begin
                state_nxt_s = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                if (core_done) begin
                    state_nxt_s = S_POLL_TX;
                    acc_req_s   = 1'b1;
                end else begin
                    state_nxt_s = S_WAIT_CORE;
                end
            end
            S_POLL_TX: begin
                if (acc_done_s) begin
                    acc_req_s = 1'b1;
                    if (acc_rdata_s[TX_OK_BIT]) begin
                        state_nxt_s   = S_WRITE_TX;
                        acc_write_s   = 1'b1;
                        acc_address_s = TX_ADDR;
                    end else begin
                        state_nxt_s = S_POLL_TX;
                    end
                end else begin
                    state_nxt_s = S_POLL_TX;
                end
            end
            S_WRITE_TX: begin
                if (acc_done_s) begin
                    acc_req_s   = 1'b1;
                    state_nxt_s = last_tx_s ? S_POLL_RX : S_POLL_TX;
                end else begin
                    state_nxt_s = S_WRITE_TX;
                end
            end
            default: begin
                state_nxt_s = S_POLL_RX;
            end
        endcase
    end

    // Operand loading, result unloading, counters and reload bookkeeping.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            cnt_r         <= CNT_ZERO;
            n_r           <= {KEY_BITS{1'b0}};
            e_r           <= {KEY_BITS{1'b0}};
            a_r           <= {KEY_BITS{1'b0}};
            result_r      <= {KEY_BITS{1'b0}};
            need_key_r    <= 1'b1;
            reload_pend_r <= 1'b0;
            core_start_r  <= 1'b0;
            busy_r        <= 1'b0;
            block_count_r <= 16'd0;
        end else begin
            core_start_r <= (state_nxt_s == S_START);
            busy_r       <= (state_nxt_s != S_POLL_RX);

            if (apply_reload_s) begin
                need_key_r    <= 1'b1;
                reload_pend_r <= 1'b0;
            end else if (state_r == S_START) begin
                need_key_r    <= 1'b0;
                reload_pend_r <= reload_pend_r || key_reload;
            end else begin
                need_key_r    <= need_key_r;
                reload_pend_r <= reload_pend_r || key_reload;
            end

            case (state_r)
                S_READ_RX: begin
                    if (acc_done_s) begin
                        if (need_key_r && (cnt_r < CNT_KB)) begin
                            n_r <= shift_in(n_r, acc_rdata_s[7:0]);
                        end else if (need_key_r && (cnt_r < CNT_2KB)) begin
                            e_r <= shift_in(e_r, acc_rdata_s[7:0]);
                        end else begin
                            a_r <= shift_in(a_r, acc_rdata_s[7:0]);
                        end
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                S_WAIT_CORE: begin
                    if (core_done) begin
                        result_r <= core_result;
                        cnt_r    <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                S_WRITE_TX: begin
                    if (acc_done_s) begin
                        result_r <= result_r << 8;
                        if (last_tx_s) begin
                            cnt_r         <= CNT_ZERO;
                            block_count_r <= block_count_r + 16'd1;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign core_start  = core_start_r;
    assign core_a      = a_r;
    assign core_e      = e_r;
    assign core_n      = n_r;
    assign busy        = busy_r;
    assign block_count = block_count_r;

endmodule

// File: tb/tb_rsa_avm_uart_ctrl.sv
// Randomized bench for rsa_avm_uart_ctrl (KEY_BITS=32): a UART/Avalon slave
// model and a modexp-core stand-in, checked against a byte-level block model.
module tb_rsa_avm_uart_ctrl;

    localparam int KEY_BITS  = 32;
    localparam int KB        = KEY_BITS / 8;
    localparam int OUT_BYTES = KB - 1;

    logic                avm_clk = 1'b0;
    logic                avm_rst = 1'b0;
    logic [4:0]          avm_address;
    logic                avm_read;
    logic [31:0]         avm_readdata = 32'd0;
    logic                avm_write;
    logic [31:0]         avm_writedata;
    logic                avm_waitrequest = 1'b0;
    logic                key_reload = 1'b0;
    logic                core_start;
    logic [KEY_BITS-1:0] core_a, core_e, core_n;
    logic [KEY_BITS-1:0] core_result = '0;
    logic                core_done = 1'b0;
    logic                busy;
    logic [15:0]         block_count;

    rsa_avm_uart_ctrl #(.KEY_BITS(KEY_BITS)) dut (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .key_reload      (key_reload),
        .core_start      (core_start),
        .core_a          (core_a),
        .core_e          (core_e),
        .core_n          (core_n),
        .core_result     (core_result),
        .core_done       (core_done),
        .busy            (busy),
        .block_count     (block_count)
    );

    always #5 avm_clk = ~avm_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state: pending UART bytes, expected operands and TX bytes.
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [95:0] exp_op_q[$];
    logic [31:0] model_n, model_e, next_result;
    bit          model_need_key;
    int          exp_blocks = 0;

    int          force_ws = -1;
    int          rx_hold = 0, tx_hold = 0, tx_hold_cfg = 0;
    int          rx_reads = 0, tx_writes = 0;

    int          ws_left;
    bit          pend, rx_ok_seen, tx_ok_seen, rxb, txb, start_prev;
    logic [38:0] saved;
    logic [31:0] r;
    int          core_wait = -1;

    // UART slave and core stand-in, both evaluated away from the active edge.
    always @(negedge avm_clk) begin
        if (avm_rst) begin
            avm_waitrequest = 1'b0;
            pend = 1'b0; rx_ok_seen = 1'b0; tx_ok_seen = 1'b0;
            core_wait = -1; core_done = 1'b0; start_prev = 1'b0;
        end else begin
            core_done = 1'b0;
            if (core_start) begin
                chk("start_pulse_width", start_prev, 1'b0);
                if (exp_op_q.size() == 0) begin
                    chk("start_unexpected", exp_op_q.size(), 1);
                end else begin
                    logic [95:0] op;
                    op = exp_op_q.pop_front();
                    chk("core_n", core_n, op[95:64]);
                    chk("core_e", core_e, op[63:32]);
                    chk("core_a", core_a, op[31:0]);
                end
                core_wait   = 5;
                core_result = $urandom;
                tx_hold     = tx_hold_cfg;
            end else if (core_wait > 0) begin
                core_wait--;
                if (core_wait == 0) begin
                    core_done   = 1'b1;
                    core_result = next_result;
                    core_wait   = -1;
                end
            end
            start_prev = core_start;

            if (avm_read || avm_write) begin
                if (pend) begin
                    chk("hold_stable", {avm_read, avm_write, avm_address, avm_writedata}, saved);
                end else begin
                    saved   = {avm_read, avm_write, avm_address, avm_writedata};
                    ws_left = (force_ws >= 0) ? force_ws : $urandom_range(0, 2);
                end
                r = $urandom;
                if (ws_left > 0) begin
                    ws_left--;
                    pend = 1'b1;
                    avm_waitrequest = 1'b1;
                    avm_readdata = r;
                end else begin
                    pend = 1'b0;
                    avm_waitrequest = 1'b0;
                    if (avm_read && !avm_write && avm_address == 5'd8) begin
                        rxb = 1'b0; txb = 1'b0;
                        if (rx_q.size() > 0) begin
                            if (rx_hold > 0) rx_hold--;
                            else rxb = 1'b1;
                        end
                        if (tx_hold > 0) tx_hold--;
                        else txb = 1'b1;
                        rx_ok_seen = rxb; tx_ok_seen = txb;
                        avm_readdata = {r[31:8], rxb, txb, r[5:0]};
                    end else if (avm_read && !avm_write && avm_address == 5'd0) begin
                        rx_reads++;
                        chk("rx_read_after_ok", rx_ok_seen, 1'b1);
                        rx_ok_seen = 1'b0;
                        if (rx_q.size() > 0) avm_readdata = {r[31:8], rx_q.pop_front()};
                        else begin
                            chk("rx_underrun", rx_q.size(), 1);
                            avm_readdata = r;
                        end
                    end else if (avm_write && !avm_read && avm_address == 5'd4) begin
                        tx_writes++;
                        chk("tx_write_after_ok", tx_ok_seen, 1'b1);
                        tx_ok_seen = 1'b0;
                        if (exp_tx_q.size() > 0) chk("tx_data", avm_writedata, {24'd0, exp_tx_q.pop_front()});
                        else chk("tx_extra", exp_tx_q.size(), 1);
                    end else begin
                        chk("bad_access", {avm_read, avm_write, avm_address}, 7'd0);
                    end
                end
            end else begin
                pend = 1'b0;
                avm_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_read"}, avm_read, 1'b1);
        chk({tag, "_write"}, avm_write, 1'b0);
        chk({tag, "_address"}, avm_address, 5'd8);
        chk({tag, "_writedata"}, avm_writedata, 32'd0);
        chk({tag, "_core_start"}, core_start, 1'b0);
        chk({tag, "_block_count"}, block_count, 16'd0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic push_word(input logic [31:0] v);
        for (int i = KB - 1; i >= 0; i--) rx_q.push_back(v[8*i +: 8]);
    endtask

    task automatic queue_block(input logic [31:0] a, input logic [31:0] res);
        rx_reads = 0;
        tx_writes = 0;
        if (model_need_key) begin
            push_word(model_n);
            push_word(model_e);
        end
        push_word(a);
        exp_op_q.push_back({model_n, model_e, a});
        next_result = res;
        for (int i = OUT_BYTES - 1; i >= 0; i--) exp_tx_q.push_back(res[8*i +: 8]);
    endtask

    task automatic run_block(input logic [31:0] a, input logic [31:0] res, input bit reload_mid_tx);
        int  exp_reads;
        int  bound;
        bit  pulsed;
        exp_reads = model_need_key ? 3 * KB : KB;
        pulsed = 1'b0;
        bound = 0;
        queue_block(a, res);
        while (!(exp_tx_q.size() == 0 && busy == 1'b0) && bound < 4000) begin
            @(negedge avm_clk);
            bound++;
            if (reload_mid_tx && !pulsed && tx_writes >= 1) begin
                key_reload = 1'b1;
                pulsed = 1'b1;
            end else begin
                key_reload = 1'b0;
            end
        end
        key_reload = 1'b0;
        if (bound >= 4000) chk("block_timeout", bound, 0);
        chk("rx_reads_per_block", rx_reads, exp_reads);
        exp_blocks++;
        chk("block_count", block_count, exp_blocks);
        model_need_key = reload_mid_tx;
        if (reload_mid_tx) begin
            model_n = $urandom;
            model_e = $urandom;
        end
    endtask

    task automatic pulse_reload_idle();
        @(negedge avm_clk);
        key_reload = 1'b1;
        @(negedge avm_clk);
        key_reload = 1'b0;
        model_need_key = 1'b1;
        model_n = $urandom;
        model_e = $urandom;
    endtask

    initial begin
        int bound;
        #1 avm_rst = 1'b1;
        repeat (3) @(negedge avm_clk);
        check_reset("por");
        avm_rst = 1'b0;

        model_need_key = 1'b1;
        model_n = 32'h0000_00CB;
        model_e = 32'h0000_0007;
        run_block(32'h0000_0011, 32'h0041_4243, 1'b0);
        run_block(32'h0000_0022, $urandom, 1'b1);
        run_block($urandom, $urandom, 1'b0);

        rx_hold = 3;
        force_ws = 4;
        run_block($urandom, $urandom, 1'b0);
        chk("rx_not_ready_polls_consumed", rx_hold, 0);
        force_ws = -1;

        tx_hold_cfg = 10;
        run_block($urandom, $urandom, 1'b0);
        chk("tx_not_ready_polls_consumed", tx_hold, 0);
        tx_hold_cfg = 0;

        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 2) == 0) pulse_reload_idle();
            run_block($urandom, $urandom, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        // Reset while a TX write is on the bus.
        queue_block($urandom, $urandom);
        bound = 0;
        while (!avm_write && bound < 4000) begin
            @(negedge avm_clk);
            bound++;
        end
        if (bound >= 4000) chk("write_wait_timeout", bound, 0);
        #2 avm_rst = 1'b1;
        #1 check_reset("midtx");
        rx_q.delete();
        exp_tx_q.delete();
        exp_op_q.delete();
        rx_hold = 0;
        exp_blocks = 0;
        model_need_key = 1'b1;
        model_n = $urandom;
        model_e = $urandom;
        repeat (2) @(negedge avm_clk);
        avm_rst = 1'b0;
        run_block($urandom, $urandom, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
